// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the HC-SR04-style echo responder.
// CyclesPerCm50M is also used by sensor_driver for its distance conversion.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHigh,
    StBurst,
    StEcho,
    StHoldoff
  } state_e;

  // 58 us/cm round-trip at 50 MHz
  localparam int unsigned CyclesPerCm50M = 2900;

  localparam int unsigned DefMinTrigCycles = 500;      // 10 us
  localparam int unsigned DefBurstCycles   = 10000;    // 200 us
  localparam int unsigned DefMaxRangeCm    = 400;
  localparam int unsigned DefTimeoutCycles = 1900000;  // 38 ms no-object echo
  localparam int unsigned DefHoldoffCycles = 50000;    // 1 ms dead time
  localparam int unsigned DefCountW        = 22;
  localparam int unsigned DefDistW         = 9;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous GPIO inputs.
// No reset: the chain keeps tracking the pin while the core is held in reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops to settle metastability
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style sensor model: answers a trigger pulse with an echo pulse whose
// width encodes distance_cm. Optional macro ECHO_JITTER_EN adds an 8-bit LFSR
// value to every echo length.
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned MIN_TRIG_CYCLES = DefMinTrigCycles,
  parameter int unsigned BURST_CYCLES    = DefBurstCycles,
  parameter int unsigned CYCLES_PER_CM   = CyclesPerCm50M,
  parameter int unsigned MAX_RANGE_CM    = DefMaxRangeCm,
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
  parameter int unsigned HOLDOFF_CYCLES  = DefHoldoffCycles,
  parameter int unsigned COUNT_W         = DefCountW,
  parameter int unsigned DIST_W          = DefDistW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              short_trig,
  output logic [7:0]        echo_count
);

  localparam logic [COUNT_W-1:0] CntOne      = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] MinTrig     = COUNT_W'(MIN_TRIG_CYCLES);
  localparam logic [COUNT_W-1:0] BurstLast   = COUNT_W'(BURST_CYCLES - 1);
  localparam logic [COUNT_W-1:0] HoldoffLast = COUNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CmLen       = COUNT_W'(CYCLES_PER_CM);
  localparam logic [COUNT_W-1:0] TimeoutLen  = COUNT_W'(TIMEOUT_CYCLES);

  logic trig_s;
  logic trig_d;
  logic trig_rise;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic               echo_q, echo_d;
  logic               short_trig_q, short_trig_d;
  logic [7:0]         echo_count_q, echo_count_d;
  logic [COUNT_W-1:0] base_len;
  logic [COUNT_W-1:0] jitter;
  logic [COUNT_W:0]   echo_elapsed;

  sync_2ff #(
    .Width(1)
  ) u_trig_sync (
    .clk_i(clk),
    .d_i  (trig),
    .q_o  (trig_s)
  );

  // Edge-detect delay is deliberately not reset: a trig held high through reset
  // must not look like a fresh rising edge once reset releases.
  always_ff @(posedge clk) begin
    trig_d <= trig_s;
  end

  assign trig_rise = trig_s & ~trig_d;

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign jitter = COUNT_W'(lfsr_q);
`else
  assign jitter = '0;
`endif

  // Echo length from the latched distance; out-of-range or zero means no object
  always_comb begin
    if (dist_q == '0 || 32'(dist_q) > MAX_RANGE_CM) begin
      base_len = TimeoutLen;
    end else begin
      base_len = COUNT_W'(dist_q) * CmLen;
    end
  end

  // One extra bit so a full-scale echo length cannot wrap the end-of-echo compare
  assign echo_elapsed = {1'b0, cnt_q} + {{COUNT_W{1'b0}}, 1'b1};

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dist_q       <= '0;
      len_q        <= '0;
      echo_q       <= 1'b0;
      short_trig_q <= 1'b0;
      echo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dist_q       <= dist_d;
      len_q        <= len_d;
      echo_q       <= echo_d;
      short_trig_q <= short_trig_d;
      echo_count_q <= echo_count_d;
    end
  end

  // Next-state logic for the trigger/burst/echo/holdoff sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dist_d       = dist_q;
    len_d        = len_q;
    echo_d       = 1'b0;
    short_trig_d = 1'b0;
    echo_count_d = echo_count_q;

    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          state_d = StTrigHigh;
          cnt_d   = CntOne;
        end
      end

      StTrigHigh: begin
        if (trig_s) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CntOne;
          end
        end else if (cnt_q >= MinTrig) begin
          dist_d  = distance_cm;
          cnt_d   = '0;
          state_d = StBurst;
        end else begin
          short_trig_d = 1'b1;
          cnt_d        = '0;
          state_d      = StIdle;
        end
      end

      StBurst: begin
        if (cnt_q >= BurstLast) begin
          len_d   = base_len + jitter;
          cnt_d   = '0;
          echo_d  = 1'b1;
          state_d = StEcho;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StEcho: begin
        if (echo_elapsed >= {1'b0, len_q}) begin
          echo_count_d = echo_count_q + 8'd1;
          cnt_d        = '0;
          state_d      = StHoldoff;
        end else begin
          cnt_d  = cnt_q + CntOne;
          echo_d = 1'b1;
        end
      end

      StHoldoff: begin
        if (cnt_q >= HoldoffLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign echo       = echo_q;
  assign busy       = (state_q != StIdle);
  assign short_trig = short_trig_q;
  assign echo_count = echo_count_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed self-checking bench for ultrasonic_echo_responder with shortened timing.
module tb_ultrasonic_echo_responder;

  localparam int unsigned MinTrig = 5;
  localparam int unsigned Burst   = 20;
  localparam int unsigned CmCyc   = 3;
  localparam int unsigned MaxCm   = 40;
  localparam int unsigned Timeout = 200;
  localparam int unsigned Holdoff = 30;
  localparam int          Bound   = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       short_trig;
  logic [7:0] echo_count;

  int checks = 0;
  int errors = 0;

  ultrasonic_echo_responder #(
    .MIN_TRIG_CYCLES(MinTrig),
    .BURST_CYCLES   (Burst),
    .CYCLES_PER_CM  (CmCyc),
    .MAX_RANGE_CM   (MaxCm),
    .TIMEOUT_CYCLES (Timeout),
    .HOLDOFF_CYCLES (Holdoff),
    .COUNT_W        (22),
    .DIST_W         (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig),
    .echo_count (echo_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_trig(input int n);
    trig = 1'b1;
    repeat (n) tick();
    trig = 1'b0;
  endtask

  // Called right after trig falls: posedges until echo rises, then echo width.
  task automatic measure_echo(output int lat, output int width);
    lat   = -1;
    width = -1;
    for (int k = 1; k <= Bound; k++) begin
      tick();
      if (echo) begin
        lat = k;
        break;
      end
    end
    if (lat > 0) begin
      width = 1;
      for (int k = 0; k < Bound; k++) begin
        tick();
        if (!echo) break;
        width++;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < Bound) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trig = 1'b0;
    distance_cm = '0;
    repeat (4) tick();
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo got %0b want 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (short_trig !== 1'b0) begin errors++; $display("FAIL reset_short got %0b want 0", short_trig); end
    checks++; if (echo_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", echo_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_valid_echo();
    int lat, width, n;
    distance_cm = 9'd10;
    pulse_trig(6);
    measure_echo(lat, width);
    checks++; if (lat !== 23) begin errors++; $display("FAIL valid_latency got %0d want 23", lat); end
    checks++; if (width !== 30) begin errors++; $display("FAIL valid_width got %0d want 30", width); end
    checks++; if (echo_count !== 8'd1) begin errors++; $display("FAIL valid_count got %0d want 1", echo_count); end
    wait_idle(n);
    checks++; if (n !== 30) begin errors++; $display("FAIL valid_holdoff got %0d want 30", n); end
    tick();
  endtask

  task automatic test_short_trig();
    int pulses = 0;
    int echoes = 0;
    distance_cm = 9'd10;
    pulse_trig(4);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (short_trig) pulses++;
      if (echo) echoes++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL short_pulses got %0d want 1", pulses); end
    checks++; if (echoes !== 0) begin errors++; $display("FAIL short_echo got %0d want 0", echoes); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %0b want 0", busy); end
    checks++; if (echo_count !== 8'd1) begin errors++; $display("FAIL short_count got %0d want 1", echo_count); end
  endtask

  task automatic test_range();
    int lat, width, n;
    int dists[3] = '{0, 41, 40};
    int wants[3] = '{200, 200, 120};
    for (int i = 0; i < 3; i++) begin
      distance_cm = 9'(dists[i]);
      pulse_trig(5);
      measure_echo(lat, width);
      checks++;
      if (width !== wants[i]) begin
        errors++;
        $display("FAIL range_width dist=%0d got %0d want %0d", dists[i], width, wants[i]);
      end
      wait_idle(n);
      tick();
    end
    checks++; if (echo_count !== 8'd4) begin errors++; $display("FAIL range_count got %0d want 4", echo_count); end
  endtask

  task automatic test_latch_retrig();
    int width = 0;
    int extra = 0;
    int k, n;
    distance_cm = 9'd20;
    pulse_trig(6);
    repeat (5) tick();
    distance_cm = 9'd5;
    k = 0;
    while (!echo && k < Bound) begin
      tick();
      k++;
    end
    while (echo && width < Bound) begin
      width++;
      if (width == 10) trig = 1'b1;
      if (width == 16) trig = 1'b0;
      tick();
    end
    trig = 1'b0;
    checks++; if (width !== 60) begin errors++; $display("FAIL latch_width got %0d want 60", width); end
    wait_idle(n);
    for (int j = 0; j < 60; j++) begin
      tick();
      if (echo || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL retrig_activity got %0d want 0", extra); end
    checks++; if (echo_count !== 8'd5) begin errors++; $display("FAIL latch_count got %0d want 5", echo_count); end
  endtask

  task automatic test_back_to_back();
    int lat, width, n;
    int busy_seen = 0;
    distance_cm = 9'd2;
    pulse_trig(6);
    measure_echo(lat, width);
    // Trigger rises during holdoff and is held well past the return to idle.
    repeat (3) tick();
    trig = 1'b1;
    wait_idle(n);
    for (int j = 0; j < 40; j++) begin
      tick();
      if (busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL holdoff_held busy got %0d want 0", busy_seen); end
    trig = 1'b0;
    repeat (3) tick();
    pulse_trig(6);
    measure_echo(lat, width);
    checks++; if (width !== 6) begin errors++; $display("FAIL fresh_width got %0d want 6", width); end
    checks++; if (echo_count !== 8'd7) begin errors++; $display("FAIL fresh_count got %0d want 7", echo_count); end
    wait_idle(n);
    tick();
  endtask

  task automatic test_reset_mid_echo();
    int lat, width, k;
    int activity = 0;
    distance_cm = 9'd10;
    pulse_trig(6);
    k = 0;
    while (!echo && k < Bound) begin
      tick();
      k++;
    end
    repeat (5) tick();
    reset = 1'b1;
    trig = 1'b1;
    tick();
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_echo got %0b want 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (echo_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", echo_count); end
    repeat (4) tick();
    reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (busy || echo) activity++;
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL rst_held_trig got %0d want 0", activity); end
    trig = 1'b0;
    repeat (3) tick();
    pulse_trig(6);
    measure_echo(lat, width);
    checks++; if (lat !== 23) begin errors++; $display("FAIL rst_latency got %0d want 23", lat); end
    checks++; if (width !== 30) begin errors++; $display("FAIL rst_width got %0d want 30", width); end
    checks++; if (echo_count !== 8'd1) begin errors++; $display("FAIL rst_after_count got %0d want 1", echo_count); end
  endtask

  initial begin
    test_reset();
    test_valid_echo();
    test_short_trig();
    test_range();
    test_latch_retrig();
    test_back_to_back();
    test_reset_mid_echo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
- Synthesizable HC-SR04-style sensor model; the responder end of the trigger/echo protocol that sensor_driver initiates.
- Accepts the driver's trigger output and returns an echo pulse whose width encodes a programmable distance.
- Used in integration benches and for hardware-in-the-loop on a spare GPIO pair, so the driver can be checked without a physical sensor.

Parameters:
- MIN_TRIG_CYCLES, 500: minimum valid trigger high time (10 us at 50 MHz).
- BURST_CYCLES, 10000: delay from trigger fall to echo rise (200 us burst).
- CYCLES_PER_CM, 2900: echo width per cm (58 us/cm).
- MAX_RANGE_CM, 400: largest distance that produces a valid echo.
- TIMEOUT_CYCLES, 1900000: echo width for no-object (38 ms).
- HOLDOFF_CYCLES, 50000: dead time after echo; triggers are ignored during it.
- COUNT_W, 22: width of the timing counter.
- DIST_W, 9: width of the distance input.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  synchronous, active-high reset.
- trig  input  1  trigger from driver; asynchronous, synchronized internally.
- distance_cm  input  DIST_W  emulated target distance; sampled once per measurement.
- echo  output  1  echo pulse to driver; registered.
- busy  output  1  high whenever the FSM is not in IDLE.
- short_trig  output  1  one-cycle pulse when a trigger shorter than MIN_TRIG_CYCLES is rejected.
- echo_count  output  8  completed echoes; wraps 255 -> 0.

Behaviour:
- Synchronizer: trig passes through two flops to give trig_s; trig_d is trig_s delayed one cycle. Rising edge is trig_s & ~trig_d.
- Reset, applied on any cycle including mid-echo:
  - State goes to IDLE; all counters clear.
  - echo=0, busy=0, short_trig=0, echo_count=0 on the next cycle.
- IDLE: a rising edge of trig_s moves to TRIG_HIGH with cnt=1. A trig held high across reset or holdoff does not start a measurement.
- TRIG_HIGH:
  - cnt increments while trig_s=1, saturating at all-ones.
  - When trig_s=0 and cnt>=MIN_TRIG_CYCLES: latch distance_cm, cnt=0, go to BURST.
  - When trig_s=0 and cnt<MIN_TRIG_CYCLES: pulse short_trig for one cycle, go to IDLE.
- BURST: counts BURST_CYCLES cycles, then loads the echo length and goes to ECHO with echo=1.
  - Echo length = latched_distance*CYCLES_PER_CM, computed at COUNT_W bits.
  - If distance is 0 or greater than MAX_RANGE_CM, echo length = TIMEOUT_CYCLES.
- ECHO:
  - echo stays high for exactly the echo length in cycles, then drops.
  - echo_count increments in the same cycle echo falls; state goes to HOLDOFF.
  - trig activity is ignored.
- HOLDOFF: counts HOLDOFF_CYCLES cycles, then goes to IDLE. All trig edges are ignored.
- Latency: echo rises exactly BURST_CYCLES+3 clk edges after the first edge that samples trig low at the pin (2 synchronizer stages + 1 FSM cycle + BURST).
- Changing distance_cm after the latch has no effect on the current echo.
- A rising edge on trig in the same cycle HOLDOFF ends is ignored; a fresh rising edge is required in IDLE.

Optional Feature:
- Macro ECHO_JITTER_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle.
  - Its value is added to the echo length when ECHO is entered, applied to valid and timeout echoes alike.
- Undefined: no LFSR; echo width is exact.

Decomposition:
- Package ultrasonic_pkg holds:
  - the state enum (IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF);
  - the default timing constants;
  - the 50 MHz cycles-per-cm constant, shared with sensor_driver's distance conversion.
- One natural sub-module, sync_2ff (generic two-flop synchronizer), reused for other GPIO inputs.

Test Plan:
- trig high 600 cycles, distance_cm=10 -> echo rises 10003 cycles after trig falls and is high exactly 29000 cycles; echo_count=1; busy low after 50000 more cycles.
- trig high 300 cycles -> short_trig pulses once; no echo; busy returns to 0; echo_count unchanged.
- distance_cm=0, then distance_cm=401, each with a valid trigger -> echo width 1900000 cycles in both cases.
- Valid trigger with distance 20; distance changed to 5 during BURST; second trigger issued mid-ECHO -> width 58000 cycles; only one echo; echo_count +1.
- reset asserted during ECHO -> next cycle echo=0, busy=0, echo_count=0; trig held high through release gives no measurement until trig drops and rises again.
- With ECHO_JITTER_EN, 20 triggers at distance 1 -> every width in [2900, 3155], not all equal, and the width sequence repeats identically after reset.
